// File: rtl/byte_order_stream_ctrl_if.sv
// Stream-side bus of byte_order_stream_ctrl: upstream read-FIFO port and
// downstream write-FIFO port. The controller uses the master view, the FIFO
// environment uses the slave view.
interface byte_order_stream_ctrl_if;
    logic        in_empty;
    logic        in_rd_en;
    logic [31:0] in_data;
    logic        out_full;
    logic        out_wr_en;
    logic [31:0] out_data;

    modport master (
        input  in_empty,
        input  in_data,
        input  out_full,
        output in_rd_en,
        output out_wr_en,
        output out_data
    );

    modport slave (
        output in_empty,
        output in_data,
        output out_full,
        input  in_rd_en,
        input  out_wr_en,
        input  out_data
    );
endinterface

// File: rtl/byte_order_stream_ctrl.sv
// Bounded word mover from an upstream read FIFO to a downstream write FIFO.
// Each captured word is byte-reordered according to the mode latched at
// start. A 2-entry buffer covers the one-cycle read latency of the upstream
// FIFO so downstream back-pressure can never cause an overflow.
module byte_order_stream_ctrl #(
    parameter int LEN_W = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic                          abort_i,
    input  logic [1:0]                    cfg_mode_i,
    input  logic [LEN_W-1:0]              cfg_len_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          aborted_o,
    output logic [LEN_W-1:0]              word_cnt_o,
    byte_order_stream_ctrl_if.master      bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Input word is [B3 B2 B1 B0] with B3 in bits 31:24.
    function automatic logic [31:0] order_bytes(input logic [31:0] w, input logic [1:0] m);
        logic [31:0] r;
        case (m)
            2'b00:   r = w;
            2'b01:   r = {w[7:0], w[15:8], w[23:16], w[31:24]};
            2'b10:   r = {w[23:16], w[31:24], w[7:0], w[15:8]};
            2'b11:   r = {w[15:0], w[31:16]};
            default: r = w;
        endcase
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  issued_q, issued_d;
    logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
    logic              inflight_q, inflight_d;
    logic [31:0]       buf0_q, buf0_d;
    logic [31:0]       buf1_q, buf1_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;

    logic              active_s;
    logic              clear_s;
    logic              rd_en_s;
    logic              wr_en_s;
    logic              push_s;
    logic [31:0]       cap_s;

    assign active_s = (state_q != ST_IDLE);
    assign clear_s  = active_s && abort_i;
    // Occupancy counts the word still in flight so the buffer can never overflow.
    assign rd_en_s  = (state_q == ST_RUN) && !bus.in_empty && !abort_i &&
                      (issued_q < len_q) &&
                      (({1'b0, cnt_q} + {2'b00, inflight_q}) < 3'd2);
    assign wr_en_s  = (cnt_q != 2'd0) && !bus.out_full && !abort_i;
    assign push_s   = inflight_q && !abort_i;
    assign cap_s    = order_bytes(bus.in_data, mode_q);

    assign bus.in_rd_en  = rd_en_s;
    assign bus.out_wr_en = wr_en_s;
    assign bus.out_data  = buf0_q;
    assign busy_o        = active_s;
    assign done_o        = done_q;
    assign aborted_o     = aborted_q;
    assign word_cnt_o    = word_cnt_q;

    // Two-entry buffer next state: buf0 is always the head.
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        cnt_d  = cnt_q;
        if (clear_s) begin
            buf0_d = 32'h0000_0000;
            buf1_d = 32'h0000_0000;
            cnt_d  = 2'd0;
        end else begin
            case ({push_s, wr_en_s})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        buf0_d = cap_s;
                    end else begin
                        buf1_d = cap_s;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    buf0_d = buf1_q;
                    cnt_d  = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        buf0_d = cap_s;
                    end else begin
                        buf0_d = buf1_q;
                        buf1_d = cap_s;
                    end
                end
                default: begin
                    cnt_d = cnt_q;
                end
            endcase
        end
    end

    // Control FSM next state, counters and completion pulses.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        len_d      = len_q;
        issued_d   = issued_q;
        word_cnt_d = word_cnt_q;
        inflight_d = rd_en_s;
        done_d     = 1'b0;
        aborted_d  = 1'b0;
        if (rd_en_s) begin
            issued_d = issued_q + LEN_W'(1);
        end else begin
            issued_d = issued_q;
        end
        if (wr_en_s) begin
            word_cnt_d = word_cnt_q + LEN_W'(1);
        end else begin
            word_cnt_d = word_cnt_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    mode_d     = cfg_mode_i;
                    len_d      = cfg_len_i;
                    word_cnt_d = {LEN_W{1'b0}};
                    issued_d   = {LEN_W{1'b0}};
                    if (cfg_len_i != {LEN_W{1'b0}}) begin
                        state_d = ST_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort_i) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (issued_d == len_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (abort_i) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (!inflight_q && (cnt_d == 2'd0)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= 2'b00;
            len_q      <= {LEN_W{1'b0}};
            issued_q   <= {LEN_W{1'b0}};
            word_cnt_q <= {LEN_W{1'b0}};
            inflight_q <= 1'b0;
            buf0_q     <= 32'h0000_0000;
            buf1_q     <= 32'h0000_0000;
            cnt_q      <= 2'd0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            word_cnt_q <= word_cnt_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

endmodule

// File: tb/tb_byte_order_stream_ctrl.sv
// Directed bench for byte_order_stream_ctrl: an upstream FIFO model feeds
// words, expected outputs go into a scoreboard queue at load time and are
// popped when the controller writes downstream.
module tb_byte_order_stream_ctrl;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_i = 1'b0;
    logic             abort_i = 1'b0;
    logic [1:0]       cfg_mode_i = 2'b00;
    logic [LEN_W-1:0] cfg_len_i = 16'd0;
    logic             busy_o;
    logic             done_o;
    logic             aborted_o;
    logic [LEN_W-1:0] word_cnt_o;

    byte_order_stream_ctrl_if bus();

    byte_order_stream_ctrl #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .cfg_mode_i (cfg_mode_i),
        .cfg_len_i  (cfg_len_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .aborted_o  (aborted_o),
        .word_cnt_o (word_cnt_o),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [31:0] src_q[$];
    logic [31:0] exp_q[$];
    int          rd_log[$];
    int          wr_log[$];
    int          done_log[$];
    int          ab_log[$];
    logic        rd_pending = 1'b0;
    int          held_m = 0;
    int          infl_m = 0;

    int base_rd = 0;
    int base_wr = 0;
    int base_done = 0;
    int base_ab = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference reordering written straight from the byte-position notation.
    function automatic logic [31:0] ref_order(input logic [31:0] w, input logic [1:0] m);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        case (m)
            2'b01:   return {b[0], b[1], b[2], b[3]};
            2'b10:   return {b[2], b[3], b[0], b[1]};
            2'b11:   return {b[1], b[0], b[3], b[2]};
            default: return w;
        endcase
    endfunction

    // Cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Upstream FIFO model: data appears the cycle after a strobe.
    always @(posedge clk) begin
        if (rd_pending && rst_n) begin
            if (src_q.size() != 0) bus.in_data <= src_q.pop_front();
            else bus.in_data <= 32'h0000_0000;
        end
        bus.in_empty <= (src_q.size() == 0);
    end

    // Output monitor: scoreboard pop, event logs and occupancy check.
    always @(negedge clk) begin
        if (bus.in_rd_en) begin
            rd_log.push_back(cyc);
            chk("rd_gate_occupancy", 32'((held_m + infl_m) < 2), 32'd1);
        end
        if (bus.out_wr_en) begin
            wr_log.push_back(cyc);
            if (exp_q.size() == 0) chk("write_with_empty_scoreboard", 32'(exp_q.size()), 32'd1);
            else chk("out_data", bus.out_data, exp_q.pop_front());
        end
        if (done_o) done_log.push_back(cyc);
        if (aborted_o) ab_log.push_back(cyc);
        if (!rst_n || (abort_i && busy_o)) begin
            held_m = 0;
            infl_m = 0;
        end else begin
            held_m = held_m + infl_m - (bus.out_wr_en ? 1 : 0);
            infl_m = bus.in_rd_en ? 1 : 0;
        end
        rd_pending = bus.in_rd_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] w, input logic [31:0] e);
        src_q.push_back(w);
        exp_q.push_back(e);
    endtask

    task automatic start_xfer(input logic [1:0] m, input logic [LEN_W-1:0] l);
        base_rd = rd_log.size();
        base_wr = wr_log.size();
        base_done = done_log.size();
        base_ab = ab_log.size();
        cfg_mode_i = m;
        cfg_len_i = l;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        cfg_mode_i = ~m;
        cfg_len_i = l + 16'd7;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_log.size() == base_done; i++) tick();
        chk("done_within_budget", 32'(done_log.size() > base_done), 32'd1);
        tick();
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int i = 0; i < budget && (wr_log.size() - base_wr) < n; i++) tick();
        chk("writes_reached", 32'((wr_log.size() - base_wr) >= n), 32'd1);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_busy"}, 32'(busy_o), 32'd0);
        chk({pfx, "_done"}, 32'(done_o), 32'd0);
        chk({pfx, "_aborted"}, 32'(aborted_o), 32'd0);
        chk({pfx, "_in_rd_en"}, 32'(bus.in_rd_en), 32'd0);
        chk({pfx, "_out_wr_en"}, 32'(bus.out_wr_en), 32'd0);
        chk({pfx, "_word_cnt"}, 32'(word_cnt_o), 32'd0);
        chk({pfx, "_out_data"}, bus.out_data, 32'd0);
    endtask

    initial begin
        logic [1:0]  modes [3];
        logic [31:0] mexp [3];
        logic [31:0] w;
        int d0;
        int a0;
        modes = '{2'b00, 2'b10, 2'b11};
        mexp  = '{32'h1122_3344, 32'h2211_4433, 32'h3344_1122};
        bus.out_full = 1'b0;

        // Reset state.
        #12;
        chk_all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Mode 01, len 4: data, latency, completion timing.
        load(32'h1122_3344, 32'h4433_2211);
        load(32'hAABB_CCDD, 32'hDDCC_BBAA);
        load(32'h0000_0001, 32'h0100_0000);
        load(32'hDEAD_BEEF, 32'hEFBE_ADDE);
        tick();
        start_xfer(2'b01, 16'd4);
        wait_done(60);
        chk("t1_first_wr_latency", 32'(wr_log[base_wr] - rd_log[base_rd]), 32'd2);
        chk("t1_done_after_last_wr", 32'(done_log[base_done] - wr_log[wr_log.size()-1]), 32'd1);
        chk("t1_word_cnt", 32'(word_cnt_o), 32'd4);
        chk("t1_writes", 32'(wr_log.size() - base_wr), 32'd4);
        chk("t1_scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("t1_busy_after", 32'(busy_o), 32'd0);

        // Other modes on one fixed word.
        for (int k = 0; k < 3; k++) begin
            load(32'h1122_3344, mexp[k]);
            tick();
            start_xfer(modes[k], 16'd1);
            wait_done(20);
            chk("mode_word_cnt", 32'(word_cnt_o), 32'd1);
            chk("mode_scoreboard_drained", 32'(exp_q.size()), 32'd0);
        end

        // start together with abort in IDLE is ignored.
        cfg_len_i = 16'd3;
        start_i = 1'b1;
        abort_i = 1'b1;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        chk("start_abort_busy", 32'(busy_o), 32'd0);
        chk("start_abort_done", 32'(done_o), 32'd0);
        chk("start_abort_word_cnt", 32'(word_cnt_o), 32'd1);

        // Zero-length transfer.
        start_xfer(2'b00, 16'd0);
        chk("len0_done", 32'(done_o), 32'd1);
        chk("len0_busy", 32'(busy_o), 32'd0);
        chk("len0_word_cnt", 32'(word_cnt_o), 32'd0);
        tick();
        chk("len0_done_cleared", 32'(done_o), 32'd0);
        chk("len0_busy_later", 32'(busy_o), 32'd0);
        chk("len0_no_reads", 32'(rd_log.size() - base_rd), 32'd0);

        // Len 16 with a 3-cycle downstream stall mid-stream.
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            load(w, ref_order(w, 2'b10));
        end
        tick();
        start_xfer(2'b10, 16'd16);
        wait_writes(6, 100);
        bus.out_full = 1'b1;
        tick();
        tick();
        tick();
        bus.out_full = 1'b0;
        wait_done(200);
        chk("bp_word_cnt", 32'(word_cnt_o), 32'd16);
        chk("bp_reads", 32'(rd_log.size() - base_rd), 32'd16);
        chk("bp_writes", 32'(wr_log.size() - base_wr), 32'd16);
        chk("bp_scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // Len 10, abort after 5 writes while a read is in flight.
        for (int i = 0; i < 10; i++) begin
            w = $urandom;
            load(w, ref_order(w, 2'b11));
        end
        tick();
        start_xfer(2'b11, 16'd10);
        wait_writes(5, 100);
        bus.out_full = 1'b1;
        for (int i = 0; i < 10 && !rd_pending; i++) tick();
        chk("abort_inflight", 32'(rd_pending), 32'd1);
        abort_i = 1'b1;
        bus.out_full = 1'b0;
        #1;
        chk("abort_cycle_rd_en", 32'(bus.in_rd_en), 32'd0);
        chk("abort_cycle_wr_en", 32'(bus.out_wr_en), 32'd0);
        tick();
        abort_i = 1'b0;
        chk("abort_pulse", 32'(aborted_o), 32'd1);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_word_cnt", 32'(word_cnt_o), 32'd5);
        chk("abort_writes", 32'(wr_log.size() - base_wr), 32'd5);
        src_q.delete();
        exp_q.delete();
        tick();
        tick();
        chk("abort_pulse_cleared", 32'(aborted_o), 32'd0);
        chk("abort_no_done", 32'(done_log.size() - base_done), 32'd0);
        chk("abort_no_late_write", 32'(wr_log.size() - base_wr), 32'd5);

        // Reset asserted in DRAIN, then a clean len-3 transfer.
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            load(w, ref_order(w, 2'b01));
        end
        tick();
        start_xfer(2'b01, 16'd3);
        for (int i = 0; i < 40 && (rd_log.size() - base_rd) < 3; i++) tick();
        chk("drain_reads_issued", 32'(rd_log.size() - base_rd), 32'd3);
        d0 = done_log.size();
        a0 = ab_log.size();
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        tick();
        tick();
        chk("midrst_no_done", 32'(done_log.size() - d0), 32'd0);
        chk("midrst_no_abort", 32'(ab_log.size() - a0), 32'd0);
        rst_n = 1'b1;
        src_q.delete();
        exp_q.delete();
        tick();
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            load(w, ref_order(w, 2'b01));
        end
        tick();
        start_xfer(2'b01, 16'd3);
        wait_done(40);
        chk("post_rst_word_cnt", 32'(word_cnt_o), 32'd3);
        chk("post_rst_writes", 32'(wr_log.size() - base_wr), 32'd3);
        chk("post_rst_scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("post_rst_no_abort", 32'(ab_log.size() - base_ab), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
